// File: rtl/sound_pkg.sv
// Shared definitions for the sound mixer: channel map, default gains,
// sequencer state encoding and the beep level helper.
package sound_pkg;

    localparam int NUM_CH   = 8;
    localparam int CH_BEEP  = 0;
    localparam int CH_AY_A  = 1;
    localparam int CH_AY_B  = 2;
    localparam int CH_AY_C  = 3;
    localparam int CH_RS_A  = 4;
    localparam int CH_RS_B  = 5;
    localparam int CH_RS_C  = 6;
    localparam int CH_COVOX = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic int default_gain(input int idx);
        if (idx == CH_BEEP)
            return 16;
        else if (idx == CH_COVOX)
            return 4;
        else
            return 8;
    endfunction

    // Tape out (bit 3) counts twice; the 0..5 count is scaled by 32.
    function automatic logic [7:0] beep_level(input logic [3:0] p);
        logic [2:0] n;
        n = {2'd0, p[0]} + {2'd0, p[1]} + {2'd0, p[2]} + {1'b0, p[3], 1'b0};
        return {n, 5'd0};
    endfunction

endpackage

// File: rtl/sound_mix_mac.sv
// Registered multiply-accumulate used once per channel by the mixer.
// Ports: clk, rst_n (sync), clr, en, sample[8], gain[GAIN_W] -> acc[16].
module sound_mix_mac #(
    parameter int GAIN_W = 5,
    parameter bit SAT    = (GAIN_W > 5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        sample,
    input  logic [GAIN_W-1:0] gain,
    output logic [15:0]       acc
);

    localparam int PW = 8 + GAIN_W;
    localparam int SW = ((PW > 16) ? PW : 16) + 1;

    logic [PW-1:0] prod;
    logic [SW-1:0] sum;

    assign prod = PW'(sample) * PW'(gain);
    assign sum  = SW'(acc) + SW'(prod);

    // Clamping only matters when wide gains can exceed 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            if (SAT && (sum[SW-1:16] != '0))
                acc <= 16'hFFFF;
            else
                acc <= sum[15:0];
        end
    end

endmodule

// File: rtl/sound_mix_sequencer.sv
// Mixer controller: once per sample period snapshots all sources and gains,
// sequences 8 channels through one MAC, and registers a 16-bit mix.
// Ports: clk24, reset_n (sync, active low), pulses, ay_sound*, rs_sound*,
// covox, cfg_we/cfg_addr/cfg_data (gain writes) -> mixed, mixed_valid, busy.
module sound_mix_sequencer
    import sound_pkg::*;
#(
    parameter int SAMPLE_DIV = 512,
    parameter int GAIN_W     = 5
) (
    input  logic              clk24,
    input  logic              reset_n,
    input  logic [3:0]        pulses,
    input  logic [7:0]        ay_soundA,
    input  logic [7:0]        ay_soundB,
    input  logic [7:0]        ay_soundC,
    input  logic [7:0]        rs_soundA,
    input  logic [7:0]        rs_soundB,
    input  logic [7:0]        rs_soundC,
    input  logic [7:0]        covox,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [GAIN_W-1:0] cfg_data,
    output logic [15:0]       mixed,
    output logic              mixed_valid,
    output logic              busy
);

    if (SAMPLE_DIV < 10 || SAMPLE_DIV > 65535) begin : g_bad_div
        $error("sound_mix_sequencer: SAMPLE_DIV must be 10..65535");
    end

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0]       div;
    logic              strobe;
    state_t            state;
    state_t            state_nx;
    logic [2:0]        ch;
    logic [2:0]        ch_nx;
    logic              mac_clr;
    logic              mac_en;
    logic [15:0]       acc;
    logic [7:0]        src   [NUM_CH];
    logic [7:0]        snap  [NUM_CH];
    logic [GAIN_W-1:0] gain  [NUM_CH];
    logic [GAIN_W-1:0] gsnap [NUM_CH];

    assign strobe = reset_n && (div == '0);
    assign busy   = (state != IDLE);

    assign src[CH_BEEP]  = beep_level(pulses);
    assign src[CH_AY_A]  = ay_soundA;
    assign src[CH_AY_B]  = ay_soundB;
    assign src[CH_AY_C]  = ay_soundC;
    assign src[CH_RS_A]  = rs_soundA;
    assign src[CH_RS_B]  = rs_soundB;
    assign src[CH_RS_C]  = rs_soundC;
    assign src[CH_COVOX] = covox;

    // Divider, gain file, snapshots and output register.
    // The snapshot reads the gain file before any same-edge write lands.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            div         <= '0;
            mixed       <= '0;
            mixed_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                gain[i]  <= GAIN_W'(default_gain(i));
                gsnap[i] <= '0;
                snap[i]  <= '0;
            end
        end else begin
            div         <= (div == DIV_LAST) ? '0 : div + 16'd1;
            mixed_valid <= 1'b0;
            if (cfg_we)
                gain[cfg_addr] <= cfg_data;
            if (strobe && state == IDLE) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i]  <= src[i];
                    gsnap[i] <= gain[i];
                end
            end
            if (state == DONE) begin
                mixed       <= acc;
                mixed_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    state_nx = ACC;
                    ch_nx    = '0;
                    mac_clr  = 1'b1;
                end
            end
            ACC: begin
                mac_en = 1'b1;
                ch_nx  = ch + 3'd1;
                if (ch == 3'(NUM_CH - 1))
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    sound_mix_mac #(
        .GAIN_W (GAIN_W)
    ) u_mac (
        .clk    (clk24),
        .rst_n  (reset_n),
        .clr    (mac_clr),
        .en     (mac_en),
        .sample (snap[ch]),
        .gain   (gsnap[ch]),
        .acc    (acc)
    );

    // A new sample period must never start while one is in flight.
    assert property (@(posedge clk24) strobe |-> state == IDLE)
        else $error("sound_mix_sequencer: strobe while busy");

endmodule

// File: tb/tb_sound_mix_sequencer.sv
// Self-checking bench for sound_mix_sequencer: directed scenarios plus
// randomized sources/gains against a plain arithmetic mix model.
module tb_sound_mix_sequencer;

    localparam int DIV = 512;

    logic        clk24 = 1'b0;
    logic        reset_n;
    logic [3:0]  pulses;
    logic [7:0]  ay_soundA;
    logic [7:0]  ay_soundB;
    logic [7:0]  ay_soundC;
    logic [7:0]  rs_soundA;
    logic [7:0]  rs_soundB;
    logic [7:0]  rs_soundC;
    logic [7:0]  covox;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic [15:0] mixed;
    logic        mixed_valid;
    logic        busy;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int t0;
    int mg [8];

    sound_mix_sequencer #(
        .SAMPLE_DIV (DIV),
        .GAIN_W     (5)
    ) dut (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .pulses      (pulses),
        .ay_soundA   (ay_soundA),
        .ay_soundB   (ay_soundB),
        .ay_soundC   (ay_soundC),
        .rs_soundA   (rs_soundA),
        .rs_soundB   (rs_soundB),
        .rs_soundC   (rs_soundC),
        .covox       (covox),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .mixed       (mixed),
        .mixed_valid (mixed_valid),
        .busy        (busy)
    );

    always #5 clk24 = ~clk24;

    always @(posedge clk24) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_mix();
        int s [8];
        int a;
        s[0] = (int'(pulses[0]) + int'(pulses[1]) + int'(pulses[2])
                + 2 * int'(pulses[3])) * 32;
        s[1] = int'(ay_soundA);
        s[2] = int'(ay_soundB);
        s[3] = int'(ay_soundC);
        s[4] = int'(rs_soundA);
        s[5] = int'(rs_soundB);
        s[6] = int'(rs_soundC);
        s[7] = int'(covox);
        a = 0;
        for (int i = 0; i < 8; i++) a += s[i] * mg[i];
        if (a > 65535) a = 65535;
        return a;
    endfunction

    task automatic set_defaults();
        mg = '{16, 8, 8, 8, 8, 8, 8, 4};
    endtask

    task automatic set_all(input logic [3:0] p, input logic [7:0] v,
                           input logic [7:0] cv);
        pulses    = p;
        ay_soundA = v; ay_soundB = v; ay_soundC = v;
        rs_soundA = v; rs_soundB = v; rs_soundC = v;
        covox     = cv;
    endtask

    task automatic rand_inputs();
        pulses    = 4'($urandom_range(0, 15));
        ay_soundA = 8'($urandom_range(0, 255));
        ay_soundB = 8'($urandom_range(0, 255));
        ay_soundC = 8'($urandom_range(0, 255));
        rs_soundA = 8'($urandom_range(0, 255));
        rs_soundB = 8'($urandom_range(0, 255));
        rs_soundC = 8'($urandom_range(0, 255));
        covox     = 8'($urandom_range(0, 255));
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = 5'(d);
        @(negedge clk24);
        cfg_we   = 1'b0;
        mg[a]    = d;
    endtask

    // Return at the negedge just before posedge number e.
    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clk24);
    endtask

    function automatic int t_of(input int k);
        return t0 + k * DIV;
    endfunction

    // Sample k strobes at t0+k*DIV and must be valid 9 edges later.
    task automatic check_sample(input int k, input int exp, input string tag);
        at_edge(t_of(k) + 9);
        chk(mixed_valid, 0, {tag, "_valid_early"});
        chk(busy, 1, {tag, "_busy_done"});
        @(negedge clk24);
        chk(mixed_valid, 1, {tag, "_valid"});
        chk(mixed, exp, {tag, "_mixed"});
        chk(busy, 0, {tag, "_busy_idle"});
        @(negedge clk24);
        chk(mixed_valid, 0, {tag, "_valid_one_cycle"});
        chk(mixed, exp, {tag, "_mixed_held"});
    endtask

    initial begin
        int exp;
        int r;
        reset_n  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        set_all(4'h0, 8'd0, 8'd0);
        set_defaults();
        repeat (4) @(negedge clk24);
        chk(mixed, 0, "reset_mixed");
        chk(mixed_valid, 0, "reset_valid");
        chk(busy, 0, "reset_busy");

        reset_n = 1'b1;
        t0 = cyc + 1;
        @(negedge clk24);
        chk(busy, 1, "first_strobe_busy");
        check_sample(0, 0, "zero_s0");
        check_sample(1, 0, "zero_s1");

        set_all(4'h0, 8'd0, 8'd0);
        ay_soundA = 8'd255;
        for (int i = 0; i < 8; i++) wr(i, (i == 1) ? 31 : 0);
        check_sample(2, 7905, "ay_a_only");

        set_all(4'hF, 8'd255, 8'd255);
        for (int i = 0; i < 8; i++) wr(i, 31);
        check_sample(3, 60295, "all_max");

        set_all(4'hF, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) wr(i, (i == 0) ? 16 : (i == 7) ? 4 : 8);
        check_sample(4, 2560, "beep_all");
        pulses = 4'b1000;
        check_sample(5, 1024, "beep_tape");

        set_all(4'h0, 8'd0, 8'd100);
        at_edge(t_of(6) + 3);
        wr(7, 0);
        check_sample(6, 400, "covox_wr_t3");
        check_sample(7, 0, "covox_after_t3");
        wr(7, 4);
        at_edge(t_of(8));
        wr(7, 0);
        check_sample(8, 400, "covox_wr_strobe");
        check_sample(9, 0, "covox_after_strobe");

        for (int k = 10; k < 16; k++) begin
            rand_inputs();
            repeat ($urandom_range(1, 6))
                wr($urandom_range(0, 7), $urandom_range(0, 31));
            exp = model_mix();
            r = $urandom_range(0, 8);
            at_edge(t_of(k) + r);
            wr($urandom_range(0, 7), $urandom_range(0, 31));
            rand_inputs();
            check_sample(k, exp, $sformatf("rand_s%0d", k));
        end

        rand_inputs();
        at_edge(t_of(16) + 5);
        reset_n = 1'b0;
        @(negedge clk24);
        chk(mixed, 0, "midrst_mixed");
        chk(busy, 0, "midrst_busy");
        chk(mixed_valid, 0, "midrst_valid");
        r = 0;
        repeat (8) begin
            @(negedge clk24);
            if (mixed_valid !== 1'b0) r++;
        end
        chk(r, 0, "midrst_no_valid");

        reset_n = 1'b1;
        t0 = cyc + 1;
        set_defaults();
        exp = model_mix();
        check_sample(0, exp, "post_rst_defaults");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
